uartprobe_uart_rx: RTL and testbench
====================================

# uartprobe_uart_rx

UART receive deserializer for the probe: samples the asynchronous serial line, recovers 8N1 frames and presents each received byte on a valid/ready stream. It sits between the device pin and the probe's register-access logic, and drives that logic's `rx_valid`/`rx_data`/`rx_ready` input stream. It provides a one-byte holding buffer, discards frames with a bad stop bit, and reports overruns.

## Interface
- `CYCLES_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range is 4 and up.
- `clk`  input  1  system clock; all logic on the rising edge.
- `aresetn`  input  1  asynchronous, active-low reset.
- `uart_rxd`  input  1  serial line, asynchronous to `clk`; idles high.
- `rx_valid`  output  1  `rx_data` holds an unconsumed byte.
- `rx_data`  output  8  received byte, LSB first on the wire.
- `rx_ready`  input  1  consumer accepts the byte when `rx_valid && rx_ready`.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low, byte discarded.
- `overrun`  output  1  one-cycle pulse: byte completed while the buffer was full, new byte discarded.

## Operation
- Synchronizer:
  - `uart_rxd` passes through two flops; reset value 1.
  - All logic uses the synchronized value `rxd_s`.
- Counters and constants:
  - N = `CYCLES_PER_BIT`, H = floor(N/2).
  - Cycle counter width is clog2(N); bit counter is 3 bits.
- States: IDLE, START, DATA, STOP.
  - IDLE: when `rxd_s` is 0, load the cycle counter and go to START.
  - START: after H cycles, sample `rxd_s`.
    - 1 (glitch): return to IDLE with no output and no flag.
    - 0: go to DATA with the bit counter at 0.
  - DATA: every N cycles, sample `rxd_s` into bit[bitcnt] of the shift register (LSB first). After bit 7, go to STOP.
  - STOP: after N cycles, sample `rxd_s`.
    - 1: deliver the byte.
    - 0: pulse `frame_err`, discard the byte.
    - In both cases return to IDLE in the same cycle, so a following start bit is detected immediately (back-to-back frames, no idle gap needed).
- Delivery:
  - Buffer empty, or being drained this cycle (`rx_valid && rx_ready`): load `rx_data`; `rx_valid` goes to 1 next cycle.
  - Buffer full and not draining: keep the old byte and pulse `overrun`.
- Handshake:
  - `rx_valid` stays high and `rx_data` stays stable until accepted.
  - `rx_valid` clears the cycle after acceptance, unless a new byte loads in the same cycle; then `rx_valid` stays 1 with the new data.
  - `rx_valid` never depends combinationally on `rx_ready`.
- Line held low (break): the frame ends in `frame_err`. Because the line is still low on return to IDLE, START is re-entered and each N·10-cycle period repeats the `frame_err` pulse until the line returns high.
- Reset values:
  - `rx_valid`=0, `rx_data`=0x00, `frame_err`=0, `overrun`=0.
  - State=IDLE, counters=0, shift register=0.
- Reset mid-frame aborts the frame; no partial byte is ever delivered.

## Timing
- Pin to `rxd_s`: 2 cycles.
- Let t0 be the first cycle `rxd_s`=0 in IDLE.
  - Start-bit sample: t0+H.
  - Data bit i (0..7) sample: t0+H+(i+1)·N.
  - Stop-bit sample: t0+H+9·N.
- `rx_valid`, `frame_err` or `overrun` are asserted at t0+H+9·N+1 (registered outputs).
- Sampling point is mid-bit, giving ±H cycles of tolerance over the frame. Baud mismatch up to about ±4% must be received correctly.
- Throughput: one byte per 10·N cycles sustained, provided the consumer accepts within 10·N cycles of `rx_valid`.

## Test plan
- N=16; send 0xA5 with 1 idle bit time before it; `rx_ready`=1.
  - Expect: `rx_valid` for exactly 1 cycle at t0+8+144+1, `rx_data`=0xA5, no flags.
- Three back-to-back frames 0x00, 0xFF, 0x3C with no idle gap; `rx_ready`=1.
  - Expect: three `rx_valid` pulses spaced exactly 160 cycles apart, in order, no flags.
- `rx_ready`=0; send 0x11 then 0x22.
  - Expect: `rx_data` holds 0x11 throughout and `overrun` pulses once at the second frame's delivery cycle.
  - Then raise `rx_ready`: 0x11 is accepted, `rx_valid` drops.
- Send 0x55 with the stop bit forced low.
  - Expect: one `frame_err` pulse, `rx_valid` stays 0.
  - Then send 0x66 normally: received as 0x66.
- Low glitch of 4 cycles (less than H=8) on an idle line.
  - Expect: return to IDLE, no output, no flags.
- Assert `aresetn` low during DATA of 0x77, release, then send 0x88.
  - Expect: all outputs 0 during reset, only 0x88 delivered afterwards.

Source files
------------

// File: rtl/uartprobe_uart_rx_if.sv
// Receive-side byte stream between the UART deserializer and the probe's
// register-access logic, plus the per-frame error pulses.
interface uartprobe_uart_rx_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx_valid,
        output rx_data,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        input  frame_err,
        input  overrun,
        output rx_ready
    );
endinterface

// File: rtl/uartprobe_uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM and a
// one-byte holding buffer presented as a valid/ready stream.
module uartprobe_uart_rx #(
    parameter int CYCLES_PER_BIT = 868
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic                       uart_rxd,
    uartprobe_uart_rx_if.master        rx
);

    localparam int N  = CYCLES_PER_BIT;
    localparam int H  = N / 2;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic            r_sync1;
    logic            r_rxdS;
    logic [CW-1:0]   r_cycleCnt;
    logic [CW-1:0]   w_cycleCntNext;
    logic [2:0]      r_bitCnt;
    logic [2:0]      w_bitCntNext;
    logic [7:0]      r_shift;
    logic [7:0]      w_shiftNext;
    logic            w_stopSample;
    logic            w_deliver;
    logic            w_badStop;
    logic            w_drain;
    logic            r_valid;
    logic [7:0]      r_data;
    logic            r_frameErr;
    logic            r_overrun;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start bit.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_sync1 <= 1'b1;
            r_rxdS  <= 1'b1;
        end else begin
            r_sync1 <= uart_rxd;
            r_rxdS  <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= S_IDLE;
            r_cycleCnt <= '0;
            r_bitCnt   <= '0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_cycleCnt <= w_cycleCntNext;
            r_bitCnt   <= w_bitCntNext;
            r_shift    <= w_shiftNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_cycleCntNext = r_cycleCnt + CW'(1);
        w_bitCntNext   = r_bitCnt;
        w_shiftNext    = r_shift;
        w_stopSample   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cycleCntNext = '0;
                if (!r_rxdS) begin
                    w_stateNext = S_START;
                end
            end
            S_START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (r_cycleCnt == HALF_LAST) begin
                    w_cycleCntNext = '0;
                    if (r_rxdS) begin
                        w_stateNext = S_IDLE;
                    end else begin
                        w_stateNext  = S_DATA;
                        w_bitCntNext = '0;
                    end
                end
            end
            S_DATA: begin
                if (r_cycleCnt == BIT_LAST) begin
                    w_cycleCntNext        = '0;
                    w_shiftNext[r_bitCnt] = r_rxdS;
                    w_bitCntNext          = r_bitCnt + 3'd1;
                    if (r_bitCnt == 3'd7) begin
                        w_stateNext = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_cycleCnt == BIT_LAST) begin
                    w_cycleCntNext = '0;
                    w_stopSample   = 1'b1;
                    w_stateNext    = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    assign w_deliver = w_stopSample && r_rxdS;
    assign w_badStop = w_stopSample && !r_rxdS;
    assign w_drain   = r_valid && rx.rx_ready;

    // A byte may load into a buffer that is being drained in the same cycle.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_valid    <= 1'b0;
            r_data     <= 8'h00;
            r_frameErr <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_frameErr <= w_badStop;
            r_overrun  <= w_deliver && r_valid && !rx.rx_ready;
            if (w_deliver && (!r_valid || w_drain)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx.rx_valid  = r_valid;
    assign rx.rx_data   = r_data;
    assign rx.frame_err = r_frameErr;
    assign rx.overrun   = r_overrun;

endmodule

// File: tb/tb_uartprobe_uart_rx.sv
// Directed bench for the UART receiver at 16 clocks per bit: framing, timing,
// back-to-back frames, overrun, frame error, glitch rejection and reset abort.
module tb_uartprobe_uart_rx;

    localparam int NB = 16;
    localparam int DELIVER_LAT = 2 + 1 + NB / 2 + 9 * NB;

    logic clk;
    logic aresetn;
    logic uart_rxd;

    uartprobe_uart_rx_if rxIf ();

    uartprobe_uart_rx #(
        .CYCLES_PER_BIT (NB)
    ) dut (
        .clk      (clk),
        .aresetn  (aresetn),
        .uart_rxd (uart_rxd),
        .rx       (rxIf)
    );

    int         cyc = 0;
    int         assertCount = 0;
    int         failCount = 0;
    int         validCycles = 0;
    int         ferrCount = 0;
    int         ferrCyc = 0;
    int         ovrCount = 0;
    int         ovrCyc = 0;
    int         holdViolations = 0;
    logic [7:0] accQ[$];
    int         accCycQ[$];
    logic       prevHeld = 1'b0;
    logic [7:0] prevData = 8'h00;

    int baseAcc;
    int baseValid;
    int baseFerr;
    int baseOvr;
    int sendCyc;
    int sendCyc2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Outputs are observed on the falling edge, half a period from any update.
    always @(negedge clk) begin
        if (rxIf.rx_valid) validCycles++;
        if (rxIf.rx_valid && rxIf.rx_ready) begin
            accQ.push_back(rxIf.rx_data);
            accCycQ.push_back(cyc);
        end
        if (rxIf.frame_err) begin
            ferrCount++;
            ferrCyc = cyc;
        end
        if (rxIf.overrun) begin
            ovrCount++;
            ovrCyc = cyc;
        end
        if (aresetn && prevHeld && (rxIf.rx_data !== prevData)) holdViolations++;
        prevHeld = rxIf.rx_valid && !rxIf.rx_ready;
        prevData = rxIf.rx_data;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] value, input logic stopBit);
        logic [9:0] frame;
        frame = {stopBit, value, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = frame[i];
            waitCycles(NB);
        end
    endtask

    task automatic takeBase();
        baseAcc   = accQ.size();
        baseValid = validCycles;
        baseFerr  = ferrCount;
        baseOvr   = ovrCount;
    endtask

    initial begin
        aresetn       = 1'b0;
        uart_rxd      = 1'b1;
        rxIf.rx_ready = 1'b1;
        waitCycles(3);

        $display("[TB] reset state");
        checkOutput("reset_valid", 32'(rxIf.rx_valid), 32'd0);
        checkOutput("reset_data", 32'(rxIf.rx_data), 32'h00);
        checkOutput("reset_ferr", 32'(rxIf.frame_err), 32'd0);
        checkOutput("reset_ovr", 32'(rxIf.overrun), 32'd0);
        aresetn = 1'b1;
        waitCycles(NB);

        $display("[TB] single frame 0xA5");
        takeBase();
        sendCyc = cyc;
        applyStimulus(8'hA5, 1'b1);
        waitCycles(20);
        checkOutput("a5_count", 32'(accQ.size() - baseAcc), 32'd1);
        checkOutput("a5_data", 32'(accQ[baseAcc]), 32'hA5);
        checkOutput("a5_time", 32'(accCycQ[baseAcc]), 32'(sendCyc + DELIVER_LAT));
        checkOutput("a5_valid_cycles", 32'(validCycles - baseValid), 32'd1);
        checkOutput("a5_ferr", 32'(ferrCount - baseFerr), 32'd0);
        checkOutput("a5_ovr", 32'(ovrCount - baseOvr), 32'd0);

        $display("[TB] back-to-back 0x00 0xFF 0x3C");
        takeBase();
        sendCyc = cyc;
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h3C, 1'b1);
        waitCycles(20);
        checkOutput("b2b_count", 32'(accQ.size() - baseAcc), 32'd3);
        checkOutput("b2b_data0", 32'(accQ[baseAcc]), 32'h00);
        checkOutput("b2b_data1", 32'(accQ[baseAcc + 1]), 32'hFF);
        checkOutput("b2b_data2", 32'(accQ[baseAcc + 2]), 32'h3C);
        checkOutput("b2b_time0", 32'(accCycQ[baseAcc]), 32'(sendCyc + DELIVER_LAT));
        checkOutput("b2b_gap01", 32'(accCycQ[baseAcc + 1] - accCycQ[baseAcc]), 32'd160);
        checkOutput("b2b_gap12", 32'(accCycQ[baseAcc + 2] - accCycQ[baseAcc + 1]), 32'd160);
        checkOutput("b2b_flags", 32'((ferrCount - baseFerr) + (ovrCount - baseOvr)), 32'd0);

        $display("[TB] overrun with consumer stalled");
        rxIf.rx_ready = 1'b0;
        takeBase();
        applyStimulus(8'h11, 1'b1);
        sendCyc2 = cyc;
        applyStimulus(8'h22, 1'b1);
        waitCycles(20);
        checkOutput("ovr_count", 32'(ovrCount - baseOvr), 32'd1);
        checkOutput("ovr_time", 32'(ovrCyc), 32'(sendCyc2 + DELIVER_LAT));
        checkOutput("ovr_held_data", 32'(rxIf.rx_data), 32'h11);
        checkOutput("ovr_held_valid", 32'(rxIf.rx_valid), 32'd1);
        checkOutput("ovr_no_accept", 32'(accQ.size() - baseAcc), 32'd0);
        checkOutput("ovr_data_stable", 32'(holdViolations), 32'd0);
        rxIf.rx_ready = 1'b1;
        waitCycles(3);
        checkOutput("ovr_drain_count", 32'(accQ.size() - baseAcc), 32'd1);
        checkOutput("ovr_drain_data", 32'(accQ[baseAcc]), 32'h11);
        checkOutput("ovr_drain_valid", 32'(rxIf.rx_valid), 32'd0);

        $display("[TB] frame error then recovery");
        takeBase();
        sendCyc = cyc;
        applyStimulus(8'h55, 1'b0);
        uart_rxd = 1'b1;
        waitCycles(2 * NB);
        checkOutput("ferr_count", 32'(ferrCount - baseFerr), 32'd1);
        checkOutput("ferr_time", 32'(ferrCyc), 32'(sendCyc + DELIVER_LAT));
        checkOutput("ferr_no_valid", 32'(validCycles - baseValid), 32'd0);
        applyStimulus(8'h66, 1'b1);
        waitCycles(20);
        checkOutput("ferr_recover_count", 32'(accQ.size() - baseAcc), 32'd1);
        checkOutput("ferr_recover_data", 32'(accQ[baseAcc]), 32'h66);
        checkOutput("ferr_recover_ferr", 32'(ferrCount - baseFerr), 32'd1);

        $display("[TB] short low glitch");
        takeBase();
        uart_rxd = 1'b0;
        waitCycles(4);
        uart_rxd = 1'b1;
        waitCycles(3 * NB);
        checkOutput("glitch_valid", 32'(validCycles - baseValid), 32'd0);
        checkOutput("glitch_ferr", 32'(ferrCount - baseFerr), 32'd0);
        checkOutput("glitch_ovr", 32'(ovrCount - baseOvr), 32'd0);
        applyStimulus(8'h5A, 1'b1);
        waitCycles(20);
        checkOutput("glitch_after_count", 32'(accQ.size() - baseAcc), 32'd1);
        checkOutput("glitch_after_data", 32'(accQ[baseAcc]), 32'h5A);

        $display("[TB] reset during frame 0x77");
        takeBase();
        uart_rxd = 1'b0;
        waitCycles(NB);
        uart_rxd = 1'b1;
        waitCycles(NB);
        uart_rxd = 1'b1;
        waitCycles(NB);
        uart_rxd = 1'b1;
        waitCycles(NB / 2);
        aresetn = 1'b0;
        waitCycles(2);
        checkOutput("midrst_valid", 32'(rxIf.rx_valid), 32'd0);
        checkOutput("midrst_data", 32'(rxIf.rx_data), 32'h00);
        checkOutput("midrst_ferr", 32'(rxIf.frame_err), 32'd0);
        checkOutput("midrst_ovr", 32'(rxIf.overrun), 32'd0);
        waitCycles(3);
        aresetn = 1'b1;
        waitCycles(NB);
        applyStimulus(8'h88, 1'b1);
        waitCycles(20);
        checkOutput("midrst_count", 32'(accQ.size() - baseAcc), 32'd1);
        checkOutput("midrst_data_after", 32'(accQ[baseAcc]), 32'h88);
        checkOutput("midrst_ferr_after", 32'(ferrCount - baseFerr), 32'd0);
        checkOutput("midrst_ovr_after", 32'(ovrCount - baseOvr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
